// File: rtl/matrix_skew_feeder.sv
// Streams a captured DIM x DIM matrix as beats of DIM lanes, optionally skewed into a systolic wavefront.
// Outputs are decoded from registers only; ready_in low freezes the beat, abort cancels without a done pulse.
module matrix_skew_feeder #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    parameter int ROW   = 1,
    parameter int SKEW  = 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]    mat_in,
    input  logic                                  ready_in,
    output logic                                  out_valid,
    output logic [DIM-1:0][WIDTH-1:0]             out_vec,
    output logic [$clog2(2*DIM)-1:0]              index,
    output logic                                  busy,
    output logic                                  done
);

    localparam int BEATS = (SKEW != 0) ? (2 * DIM - 1) : DIM;
    localparam int IW    = $clog2(2 * DIM);
    localparam int KW    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [IW-1:0]                     r_t;
    logic [IW-1:0]                     w_t_nxt;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0] r_m;
    logic                              r_done;
    logic                              w_done_nxt;
    logic                              w_load;
    logic [DIM-1:0][WIDTH-1:0]         w_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_m     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_m <= mat_in;
            end
        end
    end

    // abort wins over both a start in IDLE and a final-beat acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_STREAM;
                    w_t_nxt     = '0;
                    w_load      = 1'b1;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_t_nxt     = '0;
                end else if (ready_in) begin
                    if (r_t == LAST) begin
                        w_state_nxt = S_IDLE;
                        w_t_nxt     = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_t_nxt = r_t + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    // lane i sees element k = t - i under skew; out-of-range lanes are zero
    always_comb begin
        int            k;
        logic [KW-1:0] w_kidx;
        w_vec = '0;
        for (int i = 0; i < DIM; i++) begin
            k      = int'(r_t) - ((SKEW != 0) ? i : 0);
            w_kidx = k[KW-1:0];
            if ((r_state == S_STREAM) && (k >= 0) && (k < DIM)) begin
                w_vec[i] = (ROW != 0) ? r_m[w_kidx][i] : r_m[i][w_kidx];
            end
        end
    end

    assign out_valid = (r_state == S_STREAM);
    assign busy      = (r_state == S_STREAM);
    assign out_vec   = w_vec;
    assign index     = r_t;
    assign done      = r_done;

endmodule
